// File: rtl/riscv_trace_commit_fifo.sv
// riscv_trace_commit_fifo
// -----------------------------------------------------------------------------
// Captures every retired instruction (pc, opcode) from the core commit stage
// into a small show-ahead FIFO, and presents the entries one at a time to the
// trace-sim decoder. The commit stage is never stalled: when the FIFO is full
// and nothing leaves in the same cycle, the new entry is dropped and the loss
// is recorded (sticky overflow flag plus saturating drop counter).
//
// Handshake: an entry is transferred on every rising edge where trace_valid_o
// and trace_ready_i are both 1; trace_valid_o depends only on FIFO state,
// never on trace_ready_i, and the head entry is held stable until transferred.
//
// Optional feature (macro RISCV_TRACE_TIMESTAMP_EN): a free-running 32-bit
// cycle counter is stored with each entry and presented on trace_ts_o.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   commit_valid_i   one instruction retired this cycle
//   commit_pc_i      PC of retired instruction
//   commit_opcode_i  raw opcode of retired instruction
//   flush_i          synchronous clear of contents and loss status
//   trace_valid_o    FIFO non-empty, head entry presented
//   trace_pc_o       head entry PC (0 when empty)
//   trace_opcode_o   head entry opcode (0 when empty)
//   trace_ready_i    consumer accepts head entry this cycle
//   level_o          occupancy, 0..DEPTH
//   overflow_o       sticky: an entry was dropped since reset/flush
//   drop_count_o     saturating dropped-entry count
//   retire_count_o   wrapping count of all commit_valid_i pulses
//   trace_ts_o       head entry timestamp (only with RISCV_TRACE_TIMESTAMP_EN)
// -----------------------------------------------------------------------------
module riscv_trace_commit_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              commit_valid_i,
  input  logic [31:0]       commit_pc_i,
  input  logic [31:0]       commit_opcode_i,
  input  logic              flush_i,
  output logic              trace_valid_o,
  output logic [31:0]       trace_pc_o,
  output logic [31:0]       trace_opcode_o,
  input  logic              trace_ready_i,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o,
  output logic [31:0]       retire_count_o
`ifdef RISCV_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]       trace_ts_o
`endif
);

  // Storage (not reset: contents are only visible through valid pointers)
  logic [31:0] r_mem_pc  [DEPTH];
  logic [31:0] r_mem_op  [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_overflow;
  logic [15:0]     r_drop_count;
  logic [31:0]     r_retire_count;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[ADDR_W-1:0];
  assign w_rd_idx = r_rd_ptr[ADDR_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a commit when the head is being consumed.
  assign w_pop  = !w_empty && trace_ready_i;
  assign w_push = commit_valid_i && (!w_full || w_pop) && !flush_i;
  assign w_drop = commit_valid_i && w_full && !w_pop && !flush_i;

`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [31:0] r_mem_ts [DEPTH];
  logic [31:0] r_cycle;

  // Free-running, unaffected by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cycle <= '0;
    else         r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem_ts[w_wr_idx] <= r_cycle;
  end

  assign trace_ts_o = w_empty ? 32'd0 : r_mem_ts[w_rd_idx];
`endif

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[w_wr_idx] <= commit_pc_i;
      r_mem_op[w_wr_idx] <= commit_opcode_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (flush_i) begin
      // Flush wins over any same-cycle push or pop
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // Counts every retirement, including dropped and flushed ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             r_retire_count <= '0;
    else if (commit_valid_i) r_retire_count <= r_retire_count + 32'd1;
  end

  // Show-ahead read; zero outside valid data so the decoder never sees stale
  // storage contents.
  assign trace_valid_o  = !w_empty;
  assign trace_pc_o     = w_empty ? 32'd0 : r_mem_pc[w_rd_idx];
  assign trace_opcode_o = w_empty ? 32'd0 : r_mem_op[w_rd_idx];
  assign level_o        = r_wr_ptr - r_rd_ptr;
  assign overflow_o     = r_overflow;
  assign drop_count_o   = r_drop_count;
  assign retire_count_o = r_retire_count;

endmodule

// File: tb/tb_riscv_trace_commit_fifo.sv
// Testbench for riscv_trace_commit_fifo: directed scenarios plus a randomized
// phase. A reference model updated at each rising edge keeps the expected
// FIFO contents in exp_q; a monitor at each falling edge checks the DUT's
// presented head and status against it.
module tb_riscv_trace_commit_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              commit_valid_i = 1'b0;
  logic [31:0]       commit_pc_i = '0;
  logic [31:0]       commit_opcode_i = '0;
  logic              flush_i = 1'b0;
  logic              trace_ready_i = 1'b0;
  logic              trace_valid_o;
  logic [31:0]       trace_pc_o;
  logic [31:0]       trace_opcode_o;
  logic [ADDR_W:0]   level_o;
  logic              overflow_o;
  logic [15:0]       drop_count_o;
  logic [31:0]       retire_count_o;
`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [31:0]       trace_ts_o;
`endif

  riscv_trace_commit_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .commit_valid_i (commit_valid_i),
    .commit_pc_i    (commit_pc_i),
    .commit_opcode_i(commit_opcode_i),
    .flush_i        (flush_i),
    .trace_valid_o  (trace_valid_o),
    .trace_pc_o     (trace_pc_o),
    .trace_opcode_o (trace_opcode_o),
    .trace_ready_i  (trace_ready_i),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .drop_count_o   (drop_count_o),
    .retire_count_o (retire_count_o)
`ifdef RISCV_TRACE_TIMESTAMP_EN
    ,
    .trace_ts_o     (trace_ts_o)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries are {ts, pc, opcode}
  logic [95:0] exp_q[$];
  int          m_level  = 0;
  bit          m_ovf    = 0;
  int          m_drops  = 0;
  logic [31:0] m_retire = '0;
  logic [31:0] m_cyc    = '0;

  task automatic model_reset();
    exp_q.delete();
    m_level  = 0;
    m_ovf    = 0;
    m_drops  = 0;
    m_retire = '0;
    m_cyc    = '0;
  endtask

  always @(posedge clk_i) begin
    if (rst_ni) begin : model_step
      bit pop;
      pop = (m_level > 0) && trace_ready_i;
      if (commit_valid_i) m_retire = m_retire + 32'd1;
      if (flush_i) begin
        exp_q.delete();
        m_level = 0;
        m_ovf   = 0;
        m_drops = 0;
      end else begin
        if (commit_valid_i && (m_level < DEPTH || pop)) begin
          exp_q.push_back({m_cyc, commit_pc_i, commit_opcode_i});
          m_level++;
        end else if (commit_valid_i) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        if (pop) m_level--;
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    check("valid", {31'd0, trace_valid_o}, {31'd0, m_level > 0});
    check("level", {27'd0, level_o}, m_level);
    check("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
    check("drop_count", {16'd0, drop_count_o}, m_drops);
    check("retire_count", retire_count_o, m_retire);
    if (trace_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry_pc", trace_pc_o, 32'hxxxxxxxx);
      end else begin
        check("head_pc", trace_pc_o, exp_q[0][63:32]);
        check("head_opcode", trace_opcode_o, exp_q[0][31:0]);
`ifdef RISCV_TRACE_TIMESTAMP_EN
        check("head_ts", trace_ts_o, exp_q[0][95:64]);
`endif
        if (trace_ready_i) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_pc", trace_pc_o, 32'd0);
      check("empty_opcode", trace_opcode_o, 32'd0);
`ifdef RISCV_TRACE_TIMESTAMP_EN
      check("empty_ts", trace_ts_o, 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after a rising edge and are held for one full cycle.
  task automatic drive(input logic c, input logic [31:0] pc, input logic [31:0] op,
                       input logic rdy, input logic fl);
    commit_valid_i  = c;
    commit_pc_i     = pc;
    commit_opcode_i = op;
    trace_ready_i   = rdy;
    flush_i         = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  // Asynchronous assertion mid-cycle, release on a falling edge
  task automatic do_reset();
    #2;
    rst_ni          = 1'b0;
    commit_valid_i  = 1'b0;
    trace_ready_i   = 1'b0;
    flush_i         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (!trace_valid_o) done = 1;
      else drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    check("drain_timeout", {31'd0, trace_valid_o}, 32'd0);
    check("scoreboard_leftover", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ops5 [5];

  initial begin
    ops5[0] = 32'h06400093; ops5[1] = 32'h001080b3; ops5[2] = 32'h12345137;
    ops5[3] = 32'h00208463; ops5[4] = 32'h010000ef;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'd0, trace_valid_o}, 32'd0);
    check("rst_level", {27'd0, level_o}, 32'd0);
    check("rst_pc", trace_pc_o, 32'd0);
    check("rst_retire", retire_count_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single push, visible the cycle after, then popped
    drive(1'b1, 32'h0, 32'h06400093, 1'b0, 1'b0);
    check("t1_valid", {31'd0, trace_valid_o}, 32'd1);
    check("t1_pc", trace_pc_o, 32'h0);
    check("t1_opcode", trace_opcode_o, 32'h06400093);
    check("t1_level", {27'd0, level_o}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("t1_pop_valid", {31'd0, trace_valid_o}, 32'd0);
    check("t1_pop_level", {27'd0, level_o}, 32'd0);

    // Ordering with ready held high
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 32'(i * 4), ops5[i], 1'b1, 1'b0);
    drain(20);
    check("t2_retire", retire_count_o, 32'd5);

    // Overflow, then full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
    check("t3_level", {27'd0, level_o}, 32'd16);
    check("t3_overflow", {31'd0, overflow_o}, 32'd1);
    check("t3_drops", {16'd0, drop_count_o}, 32'd2);
    drive(1'b1, 32'h100, 32'h00000013, 1'b1, 1'b0);
    check("t4_level", {27'd0, level_o}, 32'd16);
    check("t4_drops", {16'd0, drop_count_o}, 32'd2);
    drain(40);

    // Flush together with a commit
    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, 32'h2000 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
    idle(9, 1'b1);
    check("t5_level", {27'd0, level_o}, 32'd7);
    check("t5_overflow", {31'd0, overflow_o}, 32'd1);
    drive(1'b1, 32'h3000, 32'h3, 1'b1, 1'b1);
    check("t5_flush_level", {27'd0, level_o}, 32'd0);
    check("t5_flush_valid", {31'd0, trace_valid_o}, 32'd0);
    check("t5_flush_ovf", {31'd0, overflow_o}, 32'd0);
    check("t5_flush_drops", {16'd0, drop_count_o}, 32'd0);
    check("t5_flush_retire", retire_count_o, 32'd19);
    idle(2, 1'b0);

    // Asynchronous reset between edges with entries held
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000 + 32'(i * 4), 32'h33, 1'b0, 1'b0);
    check("t6_level", {27'd0, level_o}, 32'd3);
    #2;
    rst_ni = 1'b0;
    commit_valid_i = 1'b0;
    model_reset();
    #1;
    check("t6_async_valid", {31'd0, trace_valid_o}, 32'd0);
    check("t6_async_level", {27'd0, level_o}, 32'd0);
    check("t6_async_pc", trace_pc_o, 32'd0);
    check("t6_async_opcode", trace_opcode_o, 32'd0);
    check("t6_async_retire", retire_count_o, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(3, 1'b0);
    drive(1'b1, 32'h200, 32'h00000013, 1'b0, 1'b0);
    check("t6_new_pc", trace_pc_o, 32'h200);
    check("t6_new_opcode", trace_opcode_o, 32'h00000013);
`ifdef RISCV_TRACE_TIMESTAMP_EN
    check("t6_new_ts", trace_ts_o, 32'd3);
`endif
    drain(10);

    // Randomized traffic with occasional flushes
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom, $urandom,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
    end
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time guard
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
